pulse_sched: RTL and testbench

Event scheduler feeding one `pulse_sync` clock-crossing lane from N requesters in the source clock domain. Counts events per requester, picks one round-robin, and emits one-cycle pulses spaced at least GAP cycles apart. The spacing guarantees that every toggle survives the destination synchronizer, so no crossing is lost. Sits directly upstream of `pulse_sync.i_pulse`; the grant ID travels alongside on a quasi-static side path.

---
 rtl/pulse_sched_pkg.sv | 21 ++
 rtl/pulse_sched_rr_arbiter.sv | 34 +++
 rtl/pulse_sched.sv | 142 ++++++++++++++
 tb/tb_pulse_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the pulse scheduler: FSM state encoding and a
// constant-foldable clog2 used to size ID and gap-counter fields.
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Smallest r with 2**r >= v; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pulse_sched_rr_arbiter.sv
// N-way round-robin pick: first set request at or after i_ptr, wrapping.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter
  import pulse_sched_pkg::*;
#(
  parameter  int unsigned N    = 4,
  localparam int unsigned ID_W = clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_grant_oh_c,
  output logic [ID_W-1:0] o_grant_id_c,
  output logic            o_valid_c
);

  int unsigned idx;

  always_comb begin
    o_grant_oh_c = '0;
    o_grant_id_c = '0;
    o_valid_c    = 1'b0;
    idx          = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(i_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!o_valid_c && i_req[ID_W'(idx)]) begin
        o_valid_c                  = 1'b1;
        o_grant_id_c               = ID_W'(idx);
        o_grant_oh_c[ID_W'(idx)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_sched.sv
// Per-requester event counting with round-robin issue of single-cycle pulses
// spaced GAP cycles apart, feeding one pulse_sync clock-crossing lane.
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter  int unsigned N     = 4,
  parameter  int unsigned CNT_W = 4,
  parameter  int unsigned GAP   = 8,
  localparam int unsigned ID_W  = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    i_req,
  input  logic            i_en,
  input  logic            i_ovf_clr,
  output logic            o_pulse,
  output logic [ID_W-1:0] o_grant_id,
  output logic            o_busy,
  output logic [N-1:0]    o_pend,
  output logic [N-1:0]    o_ovf
);

  localparam int unsigned      GAP_W    = clog2(GAP) + 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  gid_q, gid_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic [N-1:0]     pend_q, pend_d;
  logic [N-1:0]     ovf_q, ovf_d;

  logic [N-1:0]     grant_oh_c;
  logic [ID_W-1:0]  grant_id_c;
  logic             grant_vld_c;
  logic             issue_c;
  logic [N-1:0]     dec_c;

  // pend_q mirrors (cnt_q != 0), so it is the pre-edge request vector.
  rr_arbiter #(
    .N (N)
  ) u_arb (
    .i_req        (pend_q),
    .i_ptr        (ptr_q),
    .o_grant_oh_c (grant_oh_c),
    .o_grant_id_c (grant_id_c),
    .o_valid_c    (grant_vld_c)
  );

  // FSM next state. The final GAP cycle doubles as an idle evaluation so
  // that back-to-back pulses land exactly GAP cycles apart.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    pulse_d = 1'b0;
    issue_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        issue_c = i_en && grant_vld_c;
      end
      ST_PULSE: begin
        state_d = ST_GAP;
        gap_d   = GAP_LOAD;
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
          issue_c = i_en && grant_vld_c;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (issue_c) begin
      state_d = ST_PULSE;
      pulse_d = 1'b1;
      gid_d   = grant_id_c;
      ptr_d   = (grant_id_c == ID_LAST) ? '0 : grant_id_c + ID_W'(1);
    end
    busy_d = (state_d == ST_PULSE) || (state_d == ST_GAP);
  end

  assign dec_c = issue_c ? grant_oh_c : '0;

  // Event counters; a simultaneous event and grant cancel out.
  always_comb begin
    ovf_d  = ovf_q & ~{N{i_ovf_clr}};
    pend_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i_req[i] && !dec_c[i]) begin
        if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!i_req[i] && dec_c[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      pend_d[i] = (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '{default: '0};
      gap_q   <= '0;
      ptr_q   <= '0;
      gid_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_pulse    = pulse_q;
  assign o_grant_id = gid_q;
  assign o_busy     = busy_q;
  assign o_pend     = pend_q;
  assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_pulse_sched.sv
// Self-checking bench for pulse_sched: directed scenarios plus random traffic,
// every cycle compared against an abstract scheduling model.
module tb_pulse_sched;

  localparam int unsigned N     = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned GAP   = 8;
  localparam int unsigned ID_W  = 2;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    i_req;
  logic            i_en;
  logic            i_ovf_clr;
  logic            o_pulse;
  logic [ID_W-1:0] o_grant_id;
  logic            o_busy;
  logic [N-1:0]    o_pend;
  logic [N-1:0]    o_ovf;

  pulse_sched #(.N(N), .CNT_W(CNT_W), .GAP(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_en       (i_en),
    .i_ovf_clr  (i_ovf_clr),
    .o_pulse    (o_pulse),
    .o_grant_id (o_grant_id),
    .o_busy     (o_busy),
    .o_pend     (o_pend),
    .o_ovf      (o_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: event counts, last served requester, edges since last pulse.
  int m_cnt [N];
  bit m_ovf [N];
  int m_last;
  int m_gid;
  int m_age;
  bit m_pulse;

  // Observed DUT pulse history.
  int cyc = 0;
  int d_pulses = 0;
  int d_ids [$];
  int d_when [$];

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
    end
    m_last  = N - 1;
    m_gid   = 0;
    m_age   = GAP;
    m_pulse = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] req, input logic en, input logic clr);
    int g;
    int nv;
    bit ov;
    g = -1;
    if (en && (m_age + 1 >= GAP)) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_last + 1 + k) % N;
        if (g < 0 && m_cnt[i] > 0) g = i;
      end
    end
    for (int i = 0; i < N; i++) begin
      nv = m_cnt[i] + (req[i] ? 1 : 0) - ((g == i) ? 1 : 0);
      ov = 1'b0;
      if (nv > CMAX) begin
        nv = CMAX;
        ov = 1'b1;
      end
      m_cnt[i] = nv;
      m_ovf[i] = (m_ovf[i] && !clr) || ov;
    end
    m_pulse = (g >= 0);
    if (g >= 0) begin
      m_last = g;
      m_gid  = g;
      m_age  = 0;
    end else if (m_age < GAP) begin
      m_age++;
    end
  endtask

  task automatic compare(input string ph);
    logic [N-1:0] ep;
    logic [N-1:0] eo;
    for (int i = 0; i < N; i++) begin
      ep[i] = (m_cnt[i] != 0);
      eo[i] = m_ovf[i];
    end
    check({ph, ".pulse"}, 32'(o_pulse), 32'(m_pulse));
    check({ph, ".gid"},   32'(o_grant_id), 32'(m_gid));
    check({ph, ".busy"},  32'(o_busy), (m_age < GAP) ? 32'd1 : 32'd0);
    check({ph, ".pend"},  32'(o_pend), 32'(ep));
    check({ph, ".ovf"},   32'(o_ovf), 32'(eo));
  endtask

  task automatic step(input logic [N-1:0] req, input logic en, input logic clr, input string ph);
    @(negedge clk);
    i_req     = req;
    i_en      = en;
    i_ovf_clr = clr;
    @(posedge clk);
    model_edge(req, en, clr);
    #1;
    cyc++;
    if (o_pulse) begin
      d_pulses++;
      d_ids.push_back(32'(o_grant_id));
      d_when.push_back(cyc);
    end
    compare(ph);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    i_req     = '0;
    i_en      = 1'b0;
    i_ovf_clr = 1'b0;
    model_reset();
    #1;
    compare("rst");
    @(negedge clk);
    rst = 1'b0;
    d_ids.delete();
    d_when.delete();
  endtask

  initial begin
    int p0;
    int t0;
    int busy_n;
    logic [N-1:0] r;

    rst       = 1'b1;
    i_req     = '0;
    i_en      = 1'b0;
    i_ovf_clr = 1'b0;
    model_reset();
    #12;
    compare("reset");
    do_reset();

    // Single event: pulse after the second edge, grant 2, busy for GAP cycles.
    t0 = cyc;
    p0 = d_pulses;
    busy_n = 0;
    step(4'b0100, 1'b1, 1'b0, "single");
    for (int k = 0; k < 14; k++) begin
      step('0, 1'b1, 1'b0, "single");
      if (o_busy) busy_n++;
    end
    check("single.count", 32'(d_pulses - p0), 32'd1);
    check("single.lat", (d_when.size() > 0) ? 32'(d_when[0] - t0) : 32'd0, 32'd2);
    check("single.id", (d_ids.size() > 0) ? 32'(d_ids[0]) : 32'd99, 32'd2);
    check("single.busy_n", 32'(busy_n), GAP);

    // Simultaneous burst from a fresh pointer.
    do_reset();
    p0 = d_pulses;
    step(4'b1111, 1'b1, 1'b0, "burst");
    for (int k = 0; k < 4 * GAP + 6; k++) step('0, 1'b1, 1'b0, "burst");
    check("burst.count", 32'(d_pulses - p0), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("burst.id", (d_ids.size() > k) ? 32'(d_ids[k]) : 32'd99, 32'(k));
      if (k > 0) check("burst.space", (d_when.size() > k) ? 32'(d_when[k] - d_when[k-1]) : 32'd0, GAP);
    end
    check("burst.pend", 32'(o_pend), 32'd0);

    // Saturation with issue disabled, then drain and clear overflow.
    do_reset();
    for (int k = 0; k < 17; k++) step(4'b0010, 1'b0, 1'b0, "sat");
    check("sat.ovf", 32'(o_ovf), 32'b0010);
    p0 = d_pulses;
    for (int k = 0; k < 15 * GAP + 10; k++) step('0, 1'b1, 1'b0, "drain");
    check("sat.count", 32'(d_pulses - p0), 32'd15);
    step('0, 1'b1, 1'b1, "clr");
    check("sat.clr", 32'(o_ovf), 32'd0);

    // Requester 0 held high: steady pulses exactly GAP apart.
    do_reset();
    for (int k = 0; k < 6 * GAP; k++) step(4'b0001, 1'b1, 1'b0, "hold");
    for (int k = 1; k < d_when.size(); k++)
      check("hold.space", 32'(d_when[k] - d_when[k-1]), GAP);

    // Enable dropped 3 cycles after a pulse with two events left pending.
    do_reset();
    step(4'b0111, 1'b1, 1'b0, "endrop");
    step('0, 1'b1, 1'b0, "endrop");
    check("endrop.first", 32'(o_pulse), 32'd1);
    step('0, 1'b1, 1'b0, "endrop");
    step('0, 1'b1, 1'b0, "endrop");
    p0 = d_pulses;
    for (int k = 0; k < 2 * GAP; k++) step('0, 1'b0, 1'b0, "endrop");
    check("endrop.none", 32'(d_pulses - p0), 32'd0);
    check("endrop.busy", 32'(o_busy), 32'd0);
    step('0, 1'b1, 1'b0, "endrop");
    check("endrop.resume", 32'(o_pulse), 32'd1);

    // Asynchronous reset in the middle of a gap with events pending.
    do_reset();
    step(4'b1011, 1'b1, 1'b0, "arst");
    for (int k = 0; k < 4; k++) step('0, 1'b1, 1'b0, "arst");
    #2;
    rst = 1'b1;
    #1;
    check("arst.pulse", 32'(o_pulse), 32'd0);
    check("arst.busy", 32'(o_busy), 32'd0);
    check("arst.pend", 32'(o_pend), 32'd0);
    check("arst.gid", 32'(o_grant_id), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    p0 = d_pulses;
    for (int k = 0; k < 3 * GAP; k++) step('0, 1'b1, 1'b0, "arst");
    check("arst.quiet", 32'(d_pulses - p0), 32'd0);
    step(4'b1000, 1'b1, 1'b0, "arst");
    step('0, 1'b1, 1'b0, "arst");
    check("arst.new", 32'(o_pulse), 32'd1);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 5) == 0);
      step(r, ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
